crossing_sequencer: RTL and testbench

Sequences one train pass through the two-sensor crossing section. Measures the s1→s2 transit time in millisecond ticks, hands it to the arrival-time predictor over a start/done handshake, counts down the predicted time, then holds the crossing gate closed for a fixed interval. Sits between the debounced sensor inputs and the gate driver; the predictor is an external datapath it drives.

---
 rtl/crossing_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 30 +++
 rtl/crossing_sequencer.sv | 172 +++++++++++++++++
 tb/tb_crossing_sequencer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// Shared types and defaults for the crossing sequencer.
package crossing_pkg;

    // Default width of every millisecond counter and time value.
    localparam int TW_DEFAULT = 19;

    // Sequencer states for one train pass through the section.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MEASURE = 3'd1,
        PREDICT = 3'd2,
        WAIT    = 3'd3,
        CLOSED  = 3'd4
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Millisecond tick generator: counts 0..TICK_DIV-1 and flags the terminal count.
// clr restarts the count so a freshly entered phase begins on a whole tick.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == TERM);

    // Free-running divider, restarted from zero on clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/crossing_sequencer.sv
// Crossing sequencer: measures s1->s2 transit in ms ticks, hands it to the
// external predictor, counts down the predicted arrival time and then holds
// the gate closed for HOLD_MS ticks.
module crossing_sequencer
    import crossing_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int TW         = TW_DEFAULT,
    parameter int TIMEOUT_MS = 500000,
    parameter int HOLD_MS    = 3000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s1,
    input  logic          s2,
    output logic          pred_start,
    output logic [TW-1:0] pred_time_in,
    input  logic          pred_done,
    input  logic [TW-1:0] pred_time_out,
    output logic          gate_close,
    output logic          busy,
    output logic          timeout_err
);

    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_MS);
    localparam logic [TW-1:0] HOLD_T    = TW'(HOLD_MS);

    state_e        state_q;
    logic [1:0]    sens;
    logic [1:0]    prev_q;
    logic [1:0]    rise;
    logic          s1_rise;
    logic          s2_rise;
    logic          tick;
    logic          presc_clr;
    logic [TW-1:0] count_q;
    logic [TW-1:0] count_inc;
    logic [TW-1:0] count_d;
    logic [TW-1:0] countdown_q;
    logic [TW-1:0] hold_q;
    logic [TW-1:0] hold_d;
    logic          pred_start_q;
    logic [TW-1:0] pred_time_in_q;
    logic          gate_close_q;
    logic          timeout_err_q;

    // Bit 0 is sensor 1, bit 1 is sensor 2.
    assign sens = {s2, s1};

    // Previous samples reset high so a sensor already active at reset never reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 2'b11;
        end else begin
            prev_q <= sens;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            assign rise[gi] = sens[gi] & ~prev_q[gi];
        end
    endgenerate

    assign s1_rise = rise[0];
    assign s2_rise = rise[1];

    // Restart the tick phase whenever a timed interval begins.
    assign presc_clr = ((state_q == IDLE) && s1_rise) ||
                       ((state_q == PREDICT) && pred_done && (pred_time_out != '0));

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (presc_clr),
        .tick(tick)
    );

    // Transit count including this cycle's tick, so a capture coinciding with
    // a tick reports the full elapsed time. Saturates instead of wrapping.
    assign count_inc = (&count_q) ? count_q : count_q + TW'(1);
    assign count_d   = tick ? count_inc : count_q;
    assign hold_d    = (&hold_q) ? hold_q : hold_q + TW'(1);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            countdown_q    <= '0;
            hold_q         <= '0;
            pred_start_q   <= 1'b0;
            pred_time_in_q <= '0;
            gate_close_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            pred_start_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s1_rise) begin
                        state_q <= MEASURE;
                        count_q <= '0;
                    end
                end
                MEASURE: begin
                    // s2 takes priority over a timeout reached in the same cycle.
                    if (s2_rise) begin
                        pred_time_in_q <= count_d;
                        pred_start_q   <= 1'b1;
                        count_q        <= count_d;
                        state_q        <= PREDICT;
                    end else if (count_d >= TIMEOUT_T) begin
                        timeout_err_q <= 1'b1;
                        count_q       <= count_d;
                        state_q       <= IDLE;
                    end else begin
                        count_q <= count_d;
                    end
                end
                PREDICT: begin
                    if (pred_done) begin
                        if (pred_time_out == '0) begin
                            hold_q       <= '0;
                            gate_close_q <= 1'b1;
                            state_q      <= CLOSED;
                        end else begin
                            countdown_q <= pred_time_out;
                            state_q     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (tick) begin
                        if (countdown_q <= TW'(1)) begin
                            countdown_q  <= '0;
                            hold_q       <= '0;
                            gate_close_q <= 1'b1;
                            state_q      <= CLOSED;
                        end else begin
                            countdown_q <= countdown_q - TW'(1);
                        end
                    end
                end
                CLOSED: begin
                    if (tick) begin
                        if (hold_d >= HOLD_T) begin
                            hold_q       <= hold_d;
                            gate_close_q <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            hold_q <= hold_d;
                        end
                    end
                end
                default: begin
                    gate_close_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign pred_start   = pred_start_q;
    assign pred_time_in = pred_time_in_q;
    assign gate_close   = gate_close_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Self-checking bench for crossing_sequencer with a small behavioural model:
// transit = elapsed cycles / TICK_DIV, abort beyond TIMEOUT_MS ticks, and a
// predictor that answers after a random latency with a value derived from the transit.
module tb_crossing_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int TW         = 19;
    localparam int TIMEOUT_MS = 12;
    localparam int HOLD_MS    = 3;
    localparam int TO_CYC     = TIMEOUT_MS * TICK_DIV;
    localparam int HOLD_CYC   = HOLD_MS * TICK_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s1 = 1'b0;
    logic          s2 = 1'b0;
    logic          pred_done = 1'b0;
    logic [TW-1:0] pred_time_out = '0;
    logic          pred_start;
    logic [TW-1:0] pred_time_in;
    logic          gate_close;
    logic          busy;
    logic          timeout_err;

    int checks   = 0;
    int failures = 0;

    crossing_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .TW        (TW),
        .TIMEOUT_MS(TIMEOUT_MS),
        .HOLD_MS   (HOLD_MS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s1           (s1),
        .s2           (s2),
        .pred_start   (pred_start),
        .pred_time_in (pred_time_in),
        .pred_done    (pred_done),
        .pred_time_out(pred_time_out),
        .gate_close   (gate_close),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Reference model
    function automatic int model_transit_ms(input int cycles);
        return cycles / TICK_DIV;
    endfunction

    function automatic bit model_times_out(input int cycles);
        return cycles > TO_CYC;
    endfunction

    function automatic int model_predictor(input int t);
        return (t * 3 + 1) % 7;
    endfunction

    // Predictor answers with p, then gate rise delay and hold are measured.
    task automatic predict_and_close(input int p, input string tag);
        int n;
        bit bad;
        repeat ($urandom_range(0, 3)) cyc();
        pred_done = 1'b1;
        pred_time_out = TW'(p);
        cyc();
        pred_done = 1'b0;
        pred_time_out = '0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_done: got %b expected 1", tag, busy);
        end
        n = 0;
        while (gate_close !== 1'b1 && n < p * TICK_DIV + 8) begin
            cyc();
            n++;
        end
        if (p == 0) bad = (n != 0);
        else        bad = (n < p * TICK_DIV - 1) || (n > p * TICK_DIV + 1);
        checks++;
        if (bad || gate_close !== 1'b1) begin
            failures++;
            $display("FAIL %s gate_rise_delay: got %0d cycles expected %0d (+-1) for p=%0d", tag, n, p * TICK_DIV, p);
        end
        n = 0;
        while (gate_close === 1'b1 && n < HOLD_CYC + 8) begin
            n++;
            cyc();
        end
        if (p > 0) bad = (n != HOLD_CYC);
        else       bad = (n < HOLD_CYC - TICK_DIV + 1) || (n > HOLD_CYC);
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s gate_hold: got %0d cycles expected %0d", tag, n, HOLD_CYC);
        end
        checks++;
        if (busy !== 1'b0 || gate_close !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_with_gate_fall: got busy=%b gate=%b expected 0 0", tag, busy, gate_close);
        end
        $display("pass %s: predicted=%0d gate hold=%0d cycles", tag, p, n);
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        checks++;
        if ({pred_start, gate_close, busy, timeout_err} !== 4'b0 || pred_time_in !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got start=%b gate=%b busy=%b to=%b time=%0d expected all 0",
                     pred_start, gate_close, busy, timeout_err, pred_time_in);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || gate_close !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got busy=%b gate=%b expected 0 0", busy, gate_close);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_transit_40();
        s1 = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_s1: got %b expected 1", busy);
        end
        repeat (39) cyc();
        s2 = 1'b1;
        cyc();
        checks++;
        if (pred_start !== 1'b1 || pred_time_in !== TW'(model_transit_ms(40))) begin
            failures++;
            $display("FAIL transit40_start: got start=%b time=%0d expected 1 %0d",
                     pred_start, pred_time_in, model_transit_ms(40));
        end
        cyc();
        checks++;
        if (pred_start !== 1'b0 || pred_time_in !== TW'(model_transit_ms(40))) begin
            failures++;
            $display("FAIL transit40_pulse: got start=%b time=%0d expected 0 %0d",
                     pred_start, pred_time_in, model_transit_ms(40));
        end
        s1 = 1'b0;
        s2 = 1'b0;
        predict_and_close(5, "transit40");
    endtask

    task automatic test_simultaneous_and_zero();
        bit bad;
        s1 = 1'b1;
        s2 = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b1 || pred_start !== 1'b0) begin
            failures++;
            $display("FAIL simultaneous_edges: got busy=%b start=%b expected 1 0", busy, pred_start);
        end
        bad = 1'b0;
        repeat (5) begin
            cyc();
            if (pred_start !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL simultaneous_stays_measure: got early start or idle expected measuring");
        end
        s2 = 1'b0;
        cyc();
        s2 = 1'b1;
        cyc();
        checks++;
        if (pred_start !== 1'b1 || pred_time_in !== TW'(model_transit_ms(7))) begin
            failures++;
            $display("FAIL simultaneous_transit: got start=%b time=%0d expected 1 %0d",
                     pred_start, pred_time_in, model_transit_ms(7));
        end
        s1 = 1'b0;
        s2 = 1'b0;
        cyc();
        predict_and_close(0, "zero_predict");
    endtask

    task automatic test_ignored_edges();
        int n;
        bit bad;
        s1 = 1'b1;
        repeat (10) cyc();
        s1 = 1'b0;
        cyc();
        s1 = 1'b1;
        repeat (19) cyc();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL measure_busy: got %b expected 1", busy);
        end
        s2 = 1'b1;
        cyc();
        checks++;
        if (pred_start !== 1'b1 || pred_time_in !== TW'(model_transit_ms(30))) begin
            failures++;
            $display("FAIL s1_reedge_measure: got start=%b time=%0d expected 1 %0d",
                     pred_start, pred_time_in, model_transit_ms(30));
        end
        s1 = 1'b0;
        s2 = 1'b0;
        cyc();
        pred_done = 1'b1;
        pred_time_out = TW'(3);
        cyc();
        // In WAIT now: a fresh s1 edge and a stray pred_done must change nothing.
        pred_time_out = '0;
        s1 = 1'b1;
        bad = 1'b0;
        cyc();
        if (gate_close !== 1'b0) bad = 1'b1;
        s1 = 1'b0;
        pred_done = 1'b0;
        cyc();
        if (gate_close !== 1'b0) bad = 1'b1;
        n = 2;
        while (gate_close !== 1'b1 && n < 3 * TICK_DIV + 8) begin
            cyc();
            n++;
        end
        checks++;
        if (bad || n < 3 * TICK_DIV - 1 || n > 3 * TICK_DIV + 1) begin
            failures++;
            $display("FAIL wait_ignores_edges: got rise after %0d cycles early=%b expected %0d", n, bad, 3 * TICK_DIV);
        end
        n = 0;
        while (gate_close === 1'b1 && n < HOLD_CYC + 8) begin
            n++;
            cyc();
        end
        checks++;
        if (n != HOLD_CYC || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_hold: got hold=%0d busy=%b expected %0d 0", n, busy, HOLD_CYC);
        end
        $display("ignored edges: transit=%0d hold=%0d", pred_time_in, n);
    endtask

    task automatic test_idle_s2_and_timeout();
        int n;
        bit bad;
        bit seen_gate;
        bad = 1'b0;
        s2 = 1'b1;
        repeat (6) begin
            cyc();
            if (busy !== 1'b0 || pred_start !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_s2_ignored: got activity expected idle");
        end
        s2 = 1'b0;
        cyc();
        s1 = 1'b1;
        n = 0;
        seen_gate = 1'b0;
        while (timeout_err !== 1'b1 && n < TO_CYC + 10) begin
            cyc();
            n++;
            if (gate_close !== 1'b0) seen_gate = 1'b1;
        end
        checks++;
        if (n != TO_CYC + 1) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO_CYC + 1);
        end
        checks++;
        if (busy !== 1'b0 || seen_gate) begin
            failures++;
            $display("FAIL timeout_state: got busy=%b gate_seen=%b expected 0 0", busy, seen_gate);
        end
        cyc();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err);
        end
        s1 = 1'b0;
        cyc();
        cyc();
        $display("timeout: pulse after %0d cycles", n);
    endtask

    task automatic test_random_transits();
        for (int i = 0; i < 8; i++) begin
            int d;
            int n_drive;
            int t;
            bit to_exp;
            bit early;
            if (i == 0)      d = TO_CYC;
            else if (i == 1) d = TO_CYC + 1;
            else             d = $urandom_range(1, TO_CYC + 6);
            to_exp = model_times_out(d);
            n_drive = to_exp ? TO_CYC : d;
            early = 1'b0;
            s1 = 1'b1;
            repeat (n_drive) begin
                cyc();
                if (pred_start !== 1'b0 || timeout_err !== 1'b0 || gate_close !== 1'b0 || busy !== 1'b1)
                    early = 1'b1;
            end
            if (!to_exp) s2 = 1'b1;
            cyc();
            checks++;
            if (early) begin
                failures++;
                $display("FAIL rnd%0d_quiet_measure: got early event expected none (d=%0d)", i, d);
            end
            if (to_exp) begin
                checks++;
                if (timeout_err !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd%0d_timeout: got to=%b busy=%b expected 1 0 (d=%0d)", i, timeout_err, busy, d);
                end
                cyc();
                checks++;
                if (timeout_err !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd%0d_timeout_width: got %b expected 0", i, timeout_err);
                end
                $display("rnd%0d: d=%0d timeout", i, d);
            end else begin
                t = model_transit_ms(d);
                checks++;
                if (pred_start !== 1'b1 || pred_time_in !== TW'(t)) begin
                    failures++;
                    $display("FAIL rnd%0d_transit: got start=%b time=%0d expected 1 %0d (d=%0d)",
                             i, pred_start, pred_time_in, t, d);
                end
                cyc();
                checks++;
                if (pred_start !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd%0d_start_width: got %b expected 0", i, pred_start);
                end
                s1 = 1'b0;
                s2 = 1'b0;
                $display("rnd%0d: d=%0d transit=%0d", i, d, t);
                predict_and_close(model_predictor(t), "rnd");
            end
            s1 = 1'b0;
            s2 = 1'b0;
            cyc();
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        s1 = 1'b1;
        repeat (8) cyc();
        s2 = 1'b1;
        cyc();
        s1 = 1'b0;
        s2 = 1'b0;
        pred_done = 1'b1;
        pred_time_out = TW'(6);
        cyc();
        pred_done = 1'b0;
        pred_time_out = '0;
        repeat (5) cyc();
        checks++;
        if (busy !== 1'b1 || pred_time_in !== TW'(model_transit_ms(8))) begin
            failures++;
            $display("FAIL wait_before_reset: got busy=%b time=%0d expected 1 %0d", busy, pred_time_in, model_transit_ms(8));
        end
        rst = 1'b1;
        cyc();
        checks++;
        if ({pred_start, gate_close, busy, timeout_err} !== 4'b0 || pred_time_in !== '0) begin
            failures++;
            $display("FAIL reset_in_wait: got start=%b gate=%b busy=%b to=%b time=%0d expected all 0",
                     pred_start, gate_close, busy, timeout_err, pred_time_in);
        end
        rst = 1'b0;
        cyc();
        s1 = 1'b1;
        cyc();
        s2 = 1'b1;
        cyc();
        s1 = 1'b0;
        s2 = 1'b0;
        pred_done = 1'b1;
        pred_time_out = '0;
        cyc();
        pred_done = 1'b0;
        checks++;
        if (gate_close !== 1'b1) begin
            failures++;
            $display("FAIL closed_before_reset: got gate=%b expected 1", gate_close);
        end
        repeat (2) cyc();
        rst = 1'b1;
        s1 = 1'b1;
        cyc();
        checks++;
        if ({pred_start, gate_close, busy, timeout_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_in_closed: got start=%b gate=%b busy=%b to=%b expected all 0",
                     pred_start, gate_close, busy, timeout_err);
        end
        rst = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            cyc();
            if (busy !== 1'b0 || gate_close !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL s1_high_through_reset: got start expected idle");
        end
        s1 = 1'b0;
        cyc();
        cyc();
        $display("reset mid-operation: aborted in WAIT and CLOSED");
    endtask

    initial begin
        test_reset();
        test_transit_40();
        test_simultaneous_and_zero();
        test_ignored_edges();
        test_idle_s2_and_timeout();
        test_random_transits();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
